// File: rtl/siso_pkg.sv
// ----------------------------------------------------------------------------
// siso_pkg
// Shared constants, types and helpers for the siso serial delay line.
//   SISO_MAX_DEPTH  : largest supported number of register stages
//   siso_fill_w()   : width of the saturating fill counter for a given depth
//   siso_bit_t      : one stage of the delay line
//   SISO_STAGE_RST  : value every stage takes on reset
// ----------------------------------------------------------------------------
package siso_pkg;

    localparam int SISO_MAX_DEPTH = 64;

    typedef logic siso_bit_t;

    localparam siso_bit_t SISO_STAGE_RST = 1'b0;

    // The counter has to represent 0..depth inclusive, hence depth+1 values.
    function automatic int siso_fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : siso_pkg

// File: rtl/siso_if.sv
// ----------------------------------------------------------------------------
// siso_if
// Bundles the serial data and status signals of one siso delay line.
//   clk    : clock shared with the delay line (interface port)
//   rst    : synchronous active-high reset
//   si     : serial data in
//   so     : serial data out
//   primed : delay line holds only post-reset data
// Modports:
//   master : drives si/rst, observes so/primed
//   slave  : the delay line side
// ----------------------------------------------------------------------------
interface siso_if (
    input logic clk
);

    logic rst;
    logic si;
    logic so;
    logic primed;

    modport master (
        input  clk,
        output rst,
        output si,
        input  so,
        input  primed
    );

    modport slave (
        input  clk,
        input  rst,
        input  si,
        output so,
        output primed
    );

endinterface : siso_if

// File: rtl/siso_stage.sv
// ----------------------------------------------------------------------------
// siso_stage
// One bit of the delay line: a D flop with synchronous active-high reset.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the flop to SISO_STAGE_RST
//   d_i  : data captured on every non-reset rising edge
//   q_o  : registered output
// ----------------------------------------------------------------------------
module siso_stage
    import siso_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  siso_bit_t d_i,
    output siso_bit_t q_o
);

    siso_bit_t q_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SISO_STAGE_RST;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : siso_stage

// File: rtl/siso.sv
// ----------------------------------------------------------------------------
// siso
// Serial-in serial-out shift register: a bit sampled on si appears on so
// exactly DEPTH rising edges later. Intended as a fixed bit-delay line or
// retiming stage in bit-serial datapaths.
//   si     : serial data in, sampled every rising edge
//   clk    : single clock, all state updates on the rising edge
//   rst    : synchronous active-high reset; clears stages and fill counter
//   so     : serial data out, straight from the last stage flop
//   primed : high once DEPTH bits have been shifted in since the last reset
//   taps   : parallel view of all stages, taps[i] = stage i
//            (present only when SISO_TAPS_EN is defined)
// Parameters:
//   DEPTH  : number of stages / clocks of delay, 1..SISO_MAX_DEPTH
// Build option:
//   SISO_TAPS_EN : adds the taps output port
// ----------------------------------------------------------------------------
module siso
    import siso_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             si,
    input  logic             clk,
    input  logic             rst,
    output logic             so,
    output logic             primed
`ifdef SISO_TAPS_EN
    ,
    output logic [DEPTH-1:0] taps
`endif
);

    localparam int FILL_W = siso_fill_w(DEPTH);

    if (DEPTH < 1 || DEPTH > SISO_MAX_DEPTH) begin : g_depth_chk
        $error("siso: DEPTH must be in 1..64");
    end

    // ------------------------------------------------------------------
    // Delay line. stage_q[0] is the newest bit, stage_q[DEPTH-1] the oldest.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] stage_q;

    // NOTE: every stage is a discrete resettable flop rather than a memory
    // array, because a reset must flush all in-flight bits in one edge.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            siso_stage u_stage (
                .clk (clk),
                .rst (rst),
                .d_i (si),
                .q_o (stage_q[i])
            );
        end else begin : g_body
            siso_stage u_stage (
                .clk (clk),
                .rst (rst),
                .d_i (stage_q[i-1]),
                .q_o (stage_q[i])
            );
        end
    end

    // so comes straight off a flop, so there is no si->so path even at DEPTH=1.
    assign so = stage_q[DEPTH-1];

`ifdef SISO_TAPS_EN
    assign taps = stage_q;
`endif

    // ------------------------------------------------------------------
    // Saturating fill counter: counts post-reset shifts up to DEPTH.
    // ------------------------------------------------------------------
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    // NOTE: fill_d is given its hold value before any condition so every
    // path assigns it and no latch is inferred.
    always_comb begin
        fill_d = fill_q;
        if (fill_q != FILL_W'(DEPTH)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Decoded only from fill_q, so primed is glitch-free relative to si.
    assign primed = (fill_q == FILL_W'(DEPTH));

endmodule : siso

// File: tb/tb_siso.sv
// ----------------------------------------------------------------------------
// tb_siso
// Drives a DEPTH=4 and a DEPTH=1 siso from a shared clock and reset and
// compares every cycle against a history-queue model of the delay line.
// ----------------------------------------------------------------------------
module tb_siso;

    localparam int D4 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    siso_if bus4 (.clk(clk));
    siso_if bus1 (.clk(clk));

`ifdef SISO_TAPS_EN
    logic [D4-1:0] taps4;
    logic [D1-1:0] taps1;
`endif

    siso #(.DEPTH(D4)) dut4 (
        .si     (bus4.si),
        .clk    (clk),
        .rst    (bus4.rst),
        .so     (bus4.so),
        .primed (bus4.primed)
`ifdef SISO_TAPS_EN
        ,
        .taps   (taps4)
`endif
    );

    siso #(.DEPTH(D1)) dut1 (
        .si     (bus1.si),
        .clk    (clk),
        .rst    (bus1.rst),
        .so     (bus1.so),
        .primed (bus1.primed)
`ifdef SISO_TAPS_EN
        ,
        .taps   (taps1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: history of bits captured since the last reset.
    // The newest bit is at the back; a position exists only once that
    // many bits have been shifted in, otherwise the stage still reads 0.
    // ------------------------------------------------------------------
    bit hist4[$];
    bit hist1[$];

    function automatic bit stage_of(input bit h[$], input int i);
        if (h.size() > i) return h[h.size() - 1 - i];
        return 1'b0;
    endfunction

    task automatic model_edge(input bit s4, input bit s1, input bit r);
        if (r) begin
            hist4.delete();
            hist1.delete();
        end else begin
            hist4.push_back(s4);
            hist1.push_back(s1);
            // Only the last DEPTH bits matter once saturated; keep a bounded
            // window but never trim below DEPTH so "primed" stays derivable.
            if (hist4.size() > 2 * D4) void'(hist4.pop_front());
            if (hist1.size() > 2 * D1) void'(hist1.pop_front());
        end
    endtask

    task automatic compare_all();
        check("so4",     bus4.so,     stage_of(hist4, D4 - 1));
        check("primed4", bus4.primed, hist4.size() >= D4);
        check("so1",     bus1.so,     stage_of(hist1, D1 - 1));
        check("primed1", bus1.primed, hist1.size() >= D1);
`ifdef SISO_TAPS_EN
        begin
            logic [D4-1:0] exp_taps;
            exp_taps = '0;
            for (int i = 0; i < D4; i++) exp_taps[i] = stage_of(hist4, i);
            check("taps4", taps4, exp_taps);
            check("taps4_msb_so", taps4[D4-1], stage_of(hist4, D4 - 1));
        end
`endif
    endtask

    // One clock: drive at the falling edge, let the rising edge act,
    // then sample at the next falling edge.
    task automatic cycle(input bit s4, input bit s1, input bit r);
        bus4.si  = s4;
        bus1.si  = s1;
        bus4.rst = r;
        bus1.rst = r;
        @(posedge clk);
        model_edge(s4, s1, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit seq_a[5];
        bit seq_t[4];
        seq_a = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        seq_t = '{1'b1, 1'b0, 1'b1, 1'b1};

        bus4.si  = 1'b1;
        bus1.si  = 1'b1;
        bus4.rst = 1'b1;
        bus1.rst = 1'b1;
        @(negedge clk);

        // Reset held two edges with si=1: outputs must stay cleared.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("rst_so4", bus4.so, 1'b0);
        check("rst_primed4", bus4.primed, 1'b0);

        // Directed pattern 1,0,1,1,0 then zeros; DEPTH=1 sees 1,0,1,...
        for (int i = 0; i < 5; i++) cycle(seq_a[i], seq_a[i], 1'b0);
        // Edge 4 after release has captured the first bit's exit point.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);

        // Long run: counter must saturate and primed stay high.
        for (int i = 0; i < 100; i++) cycle(1'($urandom), 1'($urandom), 1'b0);
        check("primed_sat4", bus4.primed, 1'b1);

        // Mid-run reset flushes in-flight ones.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        check("midrst_primed4", bus4.primed, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check("midrst_no_ones", bus4.so, 1'b0);
        end

`ifdef SISO_TAPS_EN
        // Parallel view after shifting 1,0,1,1 from reset.
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(seq_t[i], seq_t[i], 1'b0);
        check("taps_1011", taps4, 4'b1011);
        check("taps_so", bus4.so, taps4[3]);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 1'($urandom), $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_siso
